// File: rtl/cbus_regfile_if.sv
// C-bus write port, data-memory handshake and register read-back bundle for cbus_regfile.
interface cbus_regfile_if #(
  parameter int DW = 19,
  parameter int MW = 8,
  parameter int AW = 19
);
  logic [3:0]    C_SEL;
  logic [DW-1:0] C_BUS;
  logic          WR_EN;
  logic          MEM_RD;
  logic          MEM_WR;
  logic          MEM_ACK;
  logic [MW-1:0] MEM_DIN;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [MW-1:0] MEM_DOUT;
  logic          BUSY;
  logic [DW-1:0] DMAR, DMDR;
  logic [DW-1:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11;

  modport master (
    output C_SEL, C_BUS, WR_EN, MEM_RD, MEM_WR, MEM_ACK, MEM_DIN,
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_DOUT, BUSY, DMAR, DMDR,
    input  R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11
  );

  modport slave (
    input  C_SEL, C_BUS, WR_EN, MEM_RD, MEM_WR, MEM_ACK, MEM_DIN,
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_DOUT, BUSY, DMAR, DMDR,
    output R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11
  );
endinterface

// File: rtl/cbus_regfile.sv
// Datapath register file written from the C bus, plus the DMAR/DMDR load/store handshake.
module cbus_regfile #(
  parameter int DW = 19,
  parameter int MW = 8,
  parameter int AW = 19
) (
  input logic           clk,
  input logic           rst,
  cbus_regfile_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t        state, state_nxt;
  logic          busy;
  logic          cmd_ld, cmd_st, ld_done;
  logic          wr_dmar, wr_dmdr;
  logic [DW-1:0] rf [12];
  logic [DW-1:0] dmar, dmdr;
  logic [AW-1:0] addr;
  logic [MW-1:0] dout;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A load wins over a simultaneous store; commands are only accepted in IDLE.
  always_comb begin
    state_nxt = state;
    cmd_ld    = 1'b0;
    cmd_st    = 1'b0;
    ld_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MEM_RD) begin
          cmd_ld    = 1'b1;
          state_nxt = LOAD;
        end else if (bus.MEM_WR) begin
          cmd_st    = 1'b1;
          state_nxt = STORE;
        end
      end
      LOAD: begin
        if (bus.MEM_ACK) begin
          ld_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      STORE: begin
        if (bus.MEM_ACK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DMAR/DMDR are frozen while a transaction is in flight so its operands stay stable.
  assign wr_dmar = bus.WR_EN && (bus.C_SEL == 4'd1) && !busy;
  assign wr_dmdr = bus.WR_EN && (bus.C_SEL == 4'd2) && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++)
        if (bus.WR_EN && (bus.C_SEL == 4'(i + 3))) rf[i] <= bus.C_BUS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmar <= '0;
      dmdr <= '0;
    end else begin
      if (wr_dmar) dmar <= bus.C_BUS;
      if (ld_done)      dmdr <= {{(DW-MW){1'b0}}, bus.MEM_DIN};
      else if (wr_dmdr) dmdr <= bus.C_BUS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      dout <= '0;
    end else begin
      if (cmd_ld || cmd_st) addr <= dmar[AW-1:0];
      if (cmd_st)           dout <= dmdr[MW-1:0];
    end
  end

  assign bus.MEM_REQ  = busy;
  assign bus.BUSY     = busy;
  assign bus.MEM_WE   = (state == STORE);
  assign bus.MEM_ADDR = addr;
  assign bus.MEM_DOUT = dout;
  assign bus.DMAR     = dmar;
  assign bus.DMDR     = dmdr;
  assign bus.R0       = rf[0];
  assign bus.R1       = rf[1];
  assign bus.R2       = rf[2];
  assign bus.R3       = rf[3];
  assign bus.R4       = rf[4];
  assign bus.R5       = rf[5];
  assign bus.R6       = rf[6];
  assign bus.R7       = rf[7];
  assign bus.R8       = rf[8];
  assign bus.R9       = rf[9];
  assign bus.R10      = rf[10];
  assign bus.R11      = rf[11];

endmodule

// File: tb/tb_cbus_regfile.sv
// Scoreboard bench for cbus_regfile: directed C-bus writes and memory load/store transactions.
module tb_cbus_regfile;

  localparam int DW = 19;
  localparam int MW = 8;
  localparam int AW = 19;

  typedef struct {
    int          idx;
    int          at;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [MW-1:0] dout;
    int            busy_len;
  } txn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  chk_t reg_q[$];
  txn_t txn_q[$];
  txn_t cur;
  logic prev_req;
  logic prev_busy;
  int   busy_cnt;

  cbus_regfile_if #(.DW(DW), .MW(MW), .AW(AW)) bus();

  cbus_regfile #(.DW(DW), .MW(MW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int idx);
    case (idx)
      0:  return 32'(bus.R0);
      1:  return 32'(bus.R1);
      2:  return 32'(bus.R2);
      3:  return 32'(bus.R3);
      4:  return 32'(bus.R4);
      5:  return 32'(bus.R5);
      6:  return 32'(bus.R6);
      7:  return 32'(bus.R7);
      8:  return 32'(bus.R8);
      9:  return 32'(bus.R9);
      10: return 32'(bus.R10);
      11: return 32'(bus.R11);
      12: return 32'(bus.DMAR);
      13: return 32'(bus.DMDR);
      14: return 32'(bus.MEM_REQ);
      15: return 32'(bus.BUSY);
      16: return 32'(bus.MEM_ADDR);
      17: return 32'(bus.MEM_WE);
      18: return 32'(bus.MEM_DOUT);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sig_name(input int idx);
    case (idx)
      12: return "DMAR";
      13: return "DMDR";
      14: return "MEM_REQ";
      15: return "BUSY";
      16: return "MEM_ADDR";
      17: return "MEM_WE";
      18: return "MEM_DOUT";
      default: return $sformatf("R%0d", idx);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected value for a DUT output, compared by the monitor at this cycle's falling edge.
  task automatic exp_at(input int idx, input logic [31:0] v);
    chk_t c;
    c.idx = idx;
    c.at  = cyc;
    c.exp = v;
    reg_q.push_back(c);
  endtask

  task automatic exp_txn(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d,
                         input int blen);
    txn_t t;
    t.we = we; t.addr = a; t.dout = d; t.busy_len = blen;
    txn_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [DW-1:0] v);
    bus.WR_EN = 1'b1; bus.C_SEL = sel; bus.C_BUS = v;
    step();
    bus.WR_EN = 1'b0; bus.C_SEL = 4'd0;
  endtask

  task automatic exp_all_zero();
    for (int i = 0; i < 19; i++) exp_at(i, 32'd0);
  endtask

  // Monitor: register/status comparisons plus memory-transaction scoreboard.
  initial begin
    prev_req  = 1'b0;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    cur       = '{we: 1'b0, addr: '0, dout: '0, busy_len: 0};
  end

  always @(negedge clk) begin : monitor
    chk_t c;
    while (reg_q.size() > 0 && reg_q[0].at <= cyc) begin
      c = reg_q.pop_front();
      check(sig_name(c.idx), dut_val(c.idx), c.exp);
    end
    if (bus.MEM_REQ && !prev_req) begin
      if (txn_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_txn @cyc %0d: got we=%0d addr=0x%0h, expected none",
                 cyc, bus.MEM_WE, bus.MEM_ADDR);
      end else begin
        cur = txn_q.pop_front();
        check("txn_we", 32'(bus.MEM_WE), 32'(cur.we));
        check("txn_addr", 32'(bus.MEM_ADDR), 32'(cur.addr));
        if (cur.we) check("txn_dout", 32'(bus.MEM_DOUT), 32'(cur.dout));
      end
    end
    if (bus.BUSY) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (cur.busy_len != 0) check("busy_len", busy_cnt, cur.busy_len);
      busy_cnt = 0;
    end
    prev_req  = bus.MEM_REQ;
    prev_busy = bus.BUSY;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.C_SEL = 4'd0; bus.C_BUS = '0; bus.WR_EN = 1'b0;
    bus.MEM_RD = 1'b0; bus.MEM_WR = 1'b0; bus.MEM_ACK = 1'b0; bus.MEM_DIN = '0;
    step(); step();
    rst = 1'b0;
    exp_all_zero();
    step();

    // Write R0..R11 through C_SEL 3..14
    for (int k = 0; k < 12; k++) begin
      wr(4'(k + 3), 19'(32'h100 + k));
      exp_at(k, 32'h100 + k);
    end
    bus.WR_EN = 1'b1; bus.C_SEL = 4'd15; bus.C_BUS = 19'h7FFFF;
    step();
    bus.WR_EN = 1'b0; bus.C_SEL = 4'd3;
    step();
    bus.C_SEL = 4'd1;
    step();
    bus.C_SEL = 4'd0;
    for (int k = 0; k < 12; k++) exp_at(k, 32'h100 + k);
    exp_at(12, 32'h0);
    exp_at(13, 32'h0);

    // Load with ACK on the third edge after the command edge
    wr(4'd1, 19'h0042A);
    exp_at(12, 32'h0042A);
    exp_txn(1'b0, 19'h0042A, 8'h00, 3);
    bus.MEM_RD = 1'b1;
    step();
    bus.MEM_RD = 1'b0;
    exp_at(14, 1); exp_at(15, 1); exp_at(16, 32'h0042A); exp_at(17, 0);
    step();
    exp_at(14, 1); exp_at(16, 32'h0042A);
    step();
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 8'hB7;
    step();
    bus.MEM_ACK = 1'b0;
    exp_at(13, 32'h000B7); exp_at(15, 0); exp_at(14, 0);

    // Store with single-cycle BUSY
    wr(4'd1, 19'h12345);
    wr(4'd2, 19'h7FF5A);
    exp_txn(1'b1, 19'h12345, 8'h5A, 1);
    bus.MEM_WR = 1'b1;
    step();
    bus.MEM_WR = 1'b0;
    exp_at(17, 1); exp_at(16, 32'h12345); exp_at(18, 32'h5A); exp_at(15, 1);
    bus.MEM_ACK = 1'b1;
    step();
    bus.MEM_ACK = 1'b0;
    exp_at(15, 0); exp_at(13, 32'h7FF5A);

    // Protection of DMAR/DMDR during a load; R0 still writable; stray MEM_WR ignored
    wr(4'd1, 19'h00300);
    exp_txn(1'b0, 19'h00300, 8'h00, 3);
    bus.MEM_RD = 1'b1;
    step();
    bus.MEM_RD = 1'b0;
    bus.WR_EN = 1'b1; bus.C_SEL = 4'd2; bus.C_BUS = 19'h11111;
    step();
    exp_at(13, 32'h7FF5A);
    bus.C_SEL = 4'd3; bus.C_BUS = 19'h22222; bus.MEM_WR = 1'b1;
    step();
    bus.MEM_WR = 1'b0;
    exp_at(0, 32'h22222); exp_at(13, 32'h7FF5A); exp_at(17, 0);
    bus.C_SEL = 4'd2; bus.C_BUS = 19'h11111;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 8'h3C;
    step();
    bus.MEM_ACK = 1'b0; bus.WR_EN = 1'b0; bus.C_SEL = 4'd0;
    exp_at(13, 32'h0003C); exp_at(15, 0); exp_at(12, 32'h00300);
    step();

    // MEM_RD and MEM_WR together: load only
    exp_txn(1'b0, 19'h00300, 8'h00, 1);
    bus.MEM_RD = 1'b1; bus.MEM_WR = 1'b1;
    step();
    bus.MEM_RD = 1'b0; bus.MEM_WR = 1'b0;
    exp_at(17, 0); exp_at(14, 1);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 8'h81;
    step();
    bus.MEM_ACK = 1'b0;
    exp_at(13, 32'h00081); exp_at(15, 0);
    step();

    // Command in the same cycle as a DMAR write: old DMAR is latched
    wr(4'd1, 19'h00001);
    exp_txn(1'b0, 19'h00001, 8'h00, 1);
    bus.WR_EN = 1'b1; bus.C_SEL = 4'd1; bus.C_BUS = 19'h00999; bus.MEM_RD = 1'b1;
    step();
    bus.WR_EN = 1'b0; bus.C_SEL = 4'd0; bus.MEM_RD = 1'b0;
    exp_at(12, 32'h00999); exp_at(16, 32'h00001);
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 8'h44;
    step();
    bus.MEM_ACK = 1'b0;
    exp_at(13, 32'h00044);
    step();

    // Reset while in LOAD aborts the load; a late ACK is ignored
    wr(4'd2, 19'h00055);
    exp_at(13, 32'h00055);
    exp_txn(1'b0, 19'h00999, 8'h00, 0);
    bus.MEM_RD = 1'b1;
    step();
    bus.MEM_RD = 1'b0;
    step();
    #1 rst = 1'b1;
    exp_all_zero();
    step();
    rst = 1'b0;
    bus.MEM_ACK = 1'b1; bus.MEM_DIN = 8'hFF;
    step();
    bus.MEM_ACK = 1'b0;
    exp_at(13, 0); exp_at(14, 0); exp_at(15, 0);
    step(); step();

    check("pending_reg_checks", reg_q.size(), 0);
    check("pending_txns", txn_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
